// File: rtl/seq_table_counter_pkg.sv
// Shared types and helpers for the programmable-sequence counter.
// Optional reverse stepping is enabled by defining SEQ_TABLE_COUNTER_REVERSE_EN.
package seq_table_counter_pkg;

   localparam logic FWD = 1'b0;
   localparam logic REV = 1'b1;

   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_LOAD = 2'd1,
      ACT_STEP = 2'd2
   } act_e;

   // Index width is clog2(depth), but never below one bit.
   function automatic int idx_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic int default_code(input int i, input int width);
      return i % (1 << width);
   endfunction

endpackage

// File: rtl/seq_table_regs.sv
// DEPTH x WIDTH code table: synchronous reset to identity codes, one write
// port and one combinational read port.
module seq_table_regs
   import seq_table_counter_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 6,
   parameter int IDX_W = 3
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             WrEn,
   input  logic [IDX_W-1:0] WrAddr,
   input  logic [WIDTH-1:0] WrData,
   input  logic [IDX_W-1:0] RdAddr,
   output logic [WIDTH-1:0] RdData
);

   localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Out-of-range write addresses match no entry and are silently dropped.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [WIDTH-1:0] DEF = WIDTH'(default_code(gi, WIDTH));
      always_ff @(posedge CLK) begin
         if (Reset) begin
            mem_q[gi] <= DEF;
         end else if (WrEn && (WrAddr == IDX_W'(gi))) begin
            mem_q[gi] <= WrData;
         end
      end
   end

   always_comb begin
      RdData = '0;
      if ({1'b0, RdAddr} < DEPTH_X) begin
         RdData = mem_q[RdAddr];
      end
   end

endmodule

// File: rtl/seq_table_counter.sv
// Steps an index through a writable code table; Q = table[Idx].
// Define SEQ_TABLE_COUNTER_REVERSE_EN to add the Dir port and reverse stepping.
module seq_table_counter
   import seq_table_counter_pkg::*;
#(
   parameter  int WIDTH = 3,
   parameter  int DEPTH = 6,
   localparam int IDX_W = idx_width(DEPTH)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Load,
   input  logic [IDX_W-1:0] LoadIdx,
   input  logic [IDX_W-1:0] Last,
   input  logic             WrEn,
   input  logic [IDX_W-1:0] WrAddr,
   input  logic [WIDTH-1:0] WrData,
`ifdef SEQ_TABLE_COUNTER_REVERSE_EN
   input  logic             Dir,
`endif
   output logic [WIDTH-1:0] Q,
   output logic [IDX_W-1:0] Idx,
   output logic             Wrap
);

   localparam logic [IDX_W:0]   DEPTH_X = (IDX_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DEPTH - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic [IDX_W-1:0] lastc;
   logic             dir;
   act_e             act;

   assign lastc = ({1'b0, Last} >= DEPTH_X) ? MAX_IDX : Last;

`ifdef SEQ_TABLE_COUNTER_REVERSE_EN
   assign dir = Dir;
`else
   assign dir = FWD;
`endif

   always_ff @(posedge CLK) begin
      if (Reset) begin
         idx_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         wrap_q <= wrap_d;
      end
   end

   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
      act    = ACT_HOLD;
      if (Load) begin
         act = ACT_LOAD;
      end else if (Enable) begin
         act = ACT_STEP;
      end

      case (act)
         ACT_LOAD: begin
            idx_d = (LoadIdx <= lastc) ? LoadIdx : '0;
         end
         ACT_STEP: begin
            // An index stranded above a lowered Last wraps like a normal end.
            if (dir == REV) begin
               if ((idx_q == '0) || (idx_q > lastc)) begin
                  idx_d  = lastc;
                  wrap_d = 1'b1;
               end else begin
                  idx_d = idx_q - IDX_W'(1);
               end
            end else begin
               if (idx_q >= lastc) begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            idx_d = idx_q;
         end
      endcase
   end

   seq_table_regs #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_regs (
      .CLK    (CLK),
      .Reset  (Reset),
      .WrEn   (WrEn),
      .WrAddr (WrAddr),
      .WrData (WrData),
      .RdAddr (idx_q),
      .RdData (Q)
   );

   assign Idx  = idx_q;
   assign Wrap = wrap_q;

endmodule

// File: tb/tb_seq_table_counter.sv
// Directed-vector bench for seq_table_counter (WIDTH=3, DEPTH=6).
module tb_seq_table_counter;

   logic       CLK = 1'b0;
   logic       Reset, Enable, Load, WrEn;
   logic [2:0] LoadIdx, Last, WrAddr, WrData;
   logic       Dir;
   logic [2:0] Q, Idx;
   logic       Wrap;

   int tests_run = 0;
   int tests_failed = 0;

   seq_table_counter #(.WIDTH(3), .DEPTH(6)) dut (
      .CLK     (CLK),
      .Reset   (Reset),
      .Enable  (Enable),
      .Load    (Load),
      .LoadIdx (LoadIdx),
      .Last    (Last),
      .WrEn    (WrEn),
      .WrAddr  (WrAddr),
      .WrData  (WrData),
`ifdef SEQ_TABLE_COUNTER_REVERSE_EN
      .Dir     (Dir),
`endif
      .Q       (Q),
      .Idx     (Idx),
      .Wrap    (Wrap)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_out(input string tag, input int q, input int idx, input int wrap);
      check_val({tag, ".Q"}, int'(Q), q);
      check_val({tag, ".Idx"}, int'(Idx), idx);
      check_val({tag, ".Wrap"}, int'(Wrap), wrap);
   endtask

   int fwd_q   [7] = '{1, 2, 3, 4, 5, 0, 1};
   int fwd_w   [7] = '{0, 0, 0, 0, 0, 1, 0};
   int prog_t  [6] = '{0, 1, 3, 5, 7, 2};
   int prog_q  [6] = '{1, 3, 5, 7, 2, 0};
   int rev_i   [5] = '{3, 2, 1, 0, 3};
   int rev_w   [5] = '{1, 0, 0, 0, 1};

   initial begin
      Reset = 1'b1; Enable = 1'b0; Load = 1'b0; WrEn = 1'b0; Dir = 1'b0;
      LoadIdx = '0; Last = 3'd5; WrAddr = '0; WrData = '0;
      tick(); tick();
      Reset = 1'b0;
      check_out("reset", 0, 0, 0);

      // Default table, forward count through a wrap
      Enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_out($sformatf("fwd%0d", i), fwd_q[i], (i + 1) % 6, fwd_w[i]);
      end

      // Program table, reload to 0 and step the new pattern
      Enable = 1'b0;
      WrEn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         WrAddr = 3'(i); WrData = 3'(prog_t[i]);
         tick();
      end
      WrEn = 1'b0;
      Load = 1'b1; LoadIdx = 3'd0;
      tick();
      Load = 1'b0;
      check_out("load0", 0, 0, 0);
      Enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_out($sformatf("prog%0d", i), prog_q[i], (i + 1) % 6, (i == 5) ? 1 : 0);
      end

      // Lower Last while sitting above it
      for (int i = 0; i < 4; i++) tick();
      check_out("at4", 7, 4, 0);
      Last = 3'd2;
      tick();
      check_out("lowered", 0, 0, 1);
      Enable = 1'b0; Load = 1'b1; LoadIdx = 3'd4;
      tick();
      check_out("load_oor", 0, 0, 0);
      LoadIdx = 3'd2;
      tick();
      check_out("load2", 3, 2, 0);

      // Last beyond DEPTH clamps to 5
      Last = 3'd7; LoadIdx = 3'd5;
      tick();
      check_out("clamp_load", 2, 5, 0);
      Load = 1'b0; Enable = 1'b1;
      tick();
      check_out("clamp_wrap", 0, 0, 1);

      // Rewrite current entry while holding
      Enable = 1'b0; WrEn = 1'b1; WrAddr = 3'd0; WrData = 3'd6;
      tick();
      WrEn = 1'b0;
      check_out("wr_cur", 6, 0, 0);
      tick();
      check_out("hold", 6, 0, 0);

      // Load beats Enable
      Load = 1'b1; Enable = 1'b1; LoadIdx = 3'd3;
      tick();
      Load = 1'b0;
      check_out("load_win", 5, 3, 0);

      // Write to next index lands together with the step
      WrEn = 1'b1; WrAddr = 3'd4; WrData = 3'd1;
      tick();
      WrEn = 1'b0;
      check_out("wr_next", 1, 4, 0);

      // Last=0: idx pinned at 0, Wrap held high
      Last = 3'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out($sformatf("last0_%0d", i), 6, 0, 1);
      end
      Enable = 1'b0;
      tick();
      check_out("last0_off", 6, 0, 0);

`ifdef SEQ_TABLE_COUNTER_REVERSE_EN
      Last = 3'd3; Load = 1'b1; LoadIdx = 3'd0;
      tick();
      Load = 1'b0; Dir = 1'b1; Enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val($sformatf("rev%0d.Idx", i), int'(Idx), rev_i[i]);
         check_val($sformatf("rev%0d.Wrap", i), int'(Wrap), rev_w[i]);
      end
      Dir = 1'b0;
`endif

      // Reset mid-run overrides write and step, restores default table
      Last = 3'd5; Enable = 1'b1; WrEn = 1'b1; WrAddr = 3'd1; WrData = 3'd7;
      Reset = 1'b1;
      tick();
      Reset = 1'b0; WrEn = 1'b0;
      check_out("rst_mid", 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_out($sformatf("post_rst%0d", i), i + 1, i + 1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
